// File: rtl/imem_refill_rv32.sv
// -----------------------------------------------------------------------------
// imem_refill_rv32
//
// Line-refill responder for the RV32 instruction cache. Owns the backing
// instruction store, accepts one miss request at a time, waits LATENCY idle
// cycles, then streams the addressed line back as LINE_WORDS 32-bit beats.
//
// Optional feature macro: IMEM_CRITWORD_EN
//   defined   : critical-word-first, the burst starts at the requested word
//               offset and wraps (offset 2 of 4 -> 2,3,0,1).
//   undefined : the burst always runs 0,1,..,LINE_WORDS-1.
//
// Parameters
//   MEMSIZE    backing store depth in 32-bit words (power of two)
//   LINE_WORDS words per line / beats per burst (power of two, 2..16)
//   LATENCY    idle cycles between request acceptance and first beat (0..15)
//
// Ports
//   iCLK, iRST         clock, synchronous active-high reset
//   iREQ, iREQADDR     refill request strobe and byte address of the miss
//   oREADY             high in IDLE, when a request can be accepted
//   oVALID, oWORD,
//   oWORDIDX, oLAST    beat valid, data, word offset in line, final beat
//   iRDY               cache accepts the current beat
//   iWE, iWADDR, iWDATA memory load port (any cycle, any state)
//   oSTATE             current FSM state, for debug/observation
//
// Handshake: a beat transfers on a rising edge where oVALID && iRDY are both
// high. While oVALID=1 and iRDY=0 the beat (oWORD, oWORDIDX, oLAST) is held
// stable. A request transfers on a rising edge where iREQ && oREADY; iREQ
// while oREADY=0 is dropped, not queued. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module imem_refill_rv32 #(
    parameter int MEMSIZE    = 1024,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iREQ,
    input  logic [31:0]                   iREQADDR,
    output logic                          oREADY,
    output logic                          oVALID,
    output logic [31:0]                   oWORD,
    output logic [$clog2(LINE_WORDS)-1:0] oWORDIDX,
    output logic                          oLAST,
    input  logic                          iRDY,
    input  logic                          iWE,
    input  logic [31:0]                   iWADDR,
    input  logic [31:0]                   iWDATA,
    output logic [1:0]                    oSTATE
);

    localparam int AW = $clog2(MEMSIZE);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int LW = AW - IW;

`ifdef IMEM_CRITWORD_EN
    localparam bit CRIT_WORD = 1'b1;
`else
    localparam bit CRIT_WORD = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    // Backing store: powers up zero, deliberately untouched by iRST.
    logic [31:0] mem [MEMSIZE] = '{default: 32'h0};

    state_t          state_q, state_d;
    logic [LW-1:0]   line_q, line_d;     // line number of the active request
    logic [IW-1:0]   off_q, off_d;       // offset of the next beat to load
    logic [IW-1:0]   beat_q, beat_d;     // ordinal of the next beat to load
    logic [3:0]      cnt_q, cnt_d;       // remaining WAIT cycles
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [31:0]     word_q, word_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [AW-1:0]   req_widx;
    logic [IW-1:0]   req_off;
    logic            load;
    logic [IW-1:0]   ld_off;
    logic [IW-1:0]   ld_beat;
    logic [AW-1:0]   rd_addr;

    assign req_widx = iREQADDR[AW+1:2];
    assign req_off  = CRIT_WORD ? req_widx[IW-1:0] : '0;

    // Address bits above the store depth and the byte lane bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iREQADDR[31:AW+2], iREQADDR[1:0],
                                iWADDR[31:AW+2], iWADDR[1:0]};

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        off_d   = off_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        valid_d = valid_q;
        last_d  = last_q;
        word_d  = word_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ld_off  = off_q;
        ld_beat = beat_q;
        rd_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (iREQ) begin
                    line_d  = req_widx[AW-1:IW];
                    ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        // No wait phase: the first beat is loaded right now.
                        load    = 1'b1;
                        ld_off  = req_off;
                        ld_beat = '0;
                        state_d = S_BURST;
                    end else begin
                        off_d   = req_off;
                        beat_d  = '0;
                        cnt_d   = 4'(LATENCY);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // cnt_q counts the WAIT cycles still to spend, so the beat is
                // loaded on the last one and appears LATENCY cycles after T+1.
                if (cnt_q == 4'd1) begin
                    load    = 1'b1;
                    state_d = S_BURST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BURST: begin
                if (valid_q && iRDY) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        if (load) begin
            rd_addr = {line_d, ld_off};
            valid_d = 1'b1;
            word_d  = mem[rd_addr];
            idx_d   = ld_off;
            last_d  = (ld_beat == IW'(LINE_WORDS - 1));
            off_d   = ld_off + 1'b1;    // wraps modulo LINE_WORDS
            beat_d  = ld_beat + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            off_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            off_q   <= off_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Load port; a read in the same cycle sees the pre-write contents.
    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem[iWADDR[AW+1:2]] <= iWDATA;
        end
    end

    assign oREADY   = ready_q;
    assign oVALID   = valid_q;
    assign oWORD    = word_q;
    assign oWORDIDX = idx_q;
    assign oLAST    = last_q;
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_imem_refill_rv32.sv
module tb_imem_refill_rv32;

`ifdef IMEM_CRITWORD_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, we;
    logic [31:0] waddr, wdata;

    // main instance, LATENCY=3
    logic        req;
    logic [31:0] reqaddr;
    logic        ready1, valid1, last1;
    logic [31:0] word1;
    logic [1:0]  idx1, st1;

    // second instance, LATENCY=0
    logic        req0;
    logic [31:0] reqaddr0;
    logic        ready0, valid0, last0;
    logic [31:0] word0;
    logic [1:0]  idx0, st0;

    imem_refill_rv32 #(.MEMSIZE(1024), .LINE_WORDS(4), .LATENCY(3)) u_dut (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iREQADDR(reqaddr),
        .oREADY(ready1), .oVALID(valid1), .oWORD(word1), .oWORDIDX(idx1),
        .oLAST(last1), .iRDY(rdy), .iWE(we), .iWADDR(waddr), .iWDATA(wdata),
        .oSTATE(st1)
    );

    imem_refill_rv32 #(.MEMSIZE(1024), .LINE_WORDS(4), .LATENCY(0)) u_dut0 (
        .iCLK(clk), .iRST(rst), .iREQ(req0), .iREQADDR(reqaddr0),
        .oREADY(ready0), .oVALID(valid0), .oWORD(word0), .oWORDIDX(idx0),
        .oLAST(last0), .iRDY(rdy), .iWE(we), .iWADDR(waddr), .iWDATA(wdata),
        .oSTATE(st0)
    );

    // observation mux: sel=0 main instance, sel=1 LATENCY=0 instance
    logic        sel;
    logic        o_ready, o_valid, o_last;
    logic [31:0] o_word;
    logic [1:0]  o_idx;
    always_comb begin
        o_ready = sel ? ready0 : ready1;
        o_valid = sel ? valid0 : valid1;
        o_last  = sel ? last0  : last1;
        o_word  = sel ? word0  : word1;
        o_idx   = sel ? idx0   : idx1;
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int widx, input logic [31:0] data);
        model[widx] = data;
        we    = 1'b1;
        waddr = widx << 2;
        wdata = data;
        tick();
        we = 1'b0;
    endtask

    // Issue one request and check its full timing and data, iRDY held high.
    // noise=1 keeps iREQ asserted (to another line) through WAIT and BURST.
    task automatic run_req(input logic [31:0] addr, input int lat, input bit noise);
        int base;
        int start;
        int off;
        base  = ((addr >> 2) % 1024) & ~3;
        start = CRIT ? ((addr >> 2) & 3) : 0;
        if (sel) begin req0 = 1'b1; reqaddr0 = addr; end
        else     begin req  = 1'b1; reqaddr  = addr; end
        tick();
        req0 = 1'b0;
        req  = 1'b0;
        if (noise) begin req = 1'b1; reqaddr = 32'h10; end
        chk("ready_drop", 32'(o_ready), 32'd0);
        for (int i = 0; i < lat; i++) begin
            chk("wait_novalid", 32'(o_valid), 32'd0);
            if (!sel) chk("wait_state", 32'(st1), 32'd1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            off = (start + k) % 4;
            chk("beat_valid", 32'(o_valid), 32'd1);
            chk("beat_idx", 32'(o_idx), 32'(off));
            chk("beat_word", o_word, model[base + off]);
            chk("beat_last", 32'(o_last), 32'(k == 3));
            chk("beat_ready", 32'(o_ready), 32'd0);
            tick();
        end
        chk("post_valid", 32'(o_valid), 32'd0);
        chk("post_ready", 32'(o_ready), 32'd1);
        chk("post_last", 32'(o_last), 32'd0);
        req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        sel = 1'b0; rst = 1'b1; rdy = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        req = 1'b0; reqaddr = '0; req0 = 1'b0; reqaddr0 = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state, both instances
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_last", 32'(last1), 32'd0);
        chk("rst_word", word1, 32'd0);
        chk("rst_idx", 32'(idx1), 32'd0);
        chk("rst_state", 32'(st1), 32'd0);
        chk("rst0_ready", 32'(ready0), 32'd1);
        chk("rst0_valid", 32'(valid0), 32'd0);

        // memory image
        wr(0, 32'h00000013);
        wr(1, 32'h00100093);
        wr(2, 32'h00200113);
        wr(3, 32'h00300193);
        wr(4, 32'h00400213);
        wr(5, 32'h00500293);
        wr(6, 32'h00600313);
        wr(7, 32'h00700393);
        for (int i = 8; i < 12; i++) wr(i, 32'hA0000000 | 32'(i));
        for (int i = 1020; i < 1024; i++) wr(i, 32'hDEAD0000 | 32'(i));

        // basic line 0: first beat at T+4, ready back at T+8
        run_req(32'h0, 3, 1'b0);

        // word 10: critical-word order or ascending, per build
        run_req(32'h28, 3, 1'b0);

        // stall on beat 1 for three cycles
        req = 1'b1; reqaddr = 32'h0;
        tick();
        req = 1'b0;
        repeat (3) tick();
        chk("stall_b0_idx", 32'(idx1), 32'd0);
        chk("stall_b0_valid", 32'(valid1), 32'd1);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(valid1), 32'd1);
            chk("stall_idx", 32'(idx1), 32'd1);
            chk("stall_word", word1, 32'h00100093);
            chk("stall_last", 32'(last1), 32'd0);
        end
        rdy = 1'b1;
        tick();
        chk("resume_b2_idx", 32'(idx1), 32'd2);
        chk("resume_b2_word", word1, 32'h00200113);
        tick();
        chk("resume_b3_idx", 32'(idx1), 32'd3);
        chk("resume_b3_last", 32'(last1), 32'd1);
        tick();
        chk("resume_done_valid", 32'(valid1), 32'd0);
        chk("resume_done_ready", 32'(ready1), 32'd1);

        // requests during WAIT and BURST are dropped
        run_req(32'h0, 3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_extra_burst", 32'(valid1), 32'd0);
            chk("no_extra_ready", 32'(ready1), 32'd1);
        end
        run_req(32'h10, 3, 1'b0);

        // reset while beat 2 is presented
        req = 1'b1; reqaddr = 32'h0;
        tick();
        req = 1'b0;
        repeat (5) tick();
        chk("pre_rst_idx", 32'(idx1), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(valid1), 32'd0);
        chk("midrst_ready", 32'(ready1), 32'd1);
        chk("midrst_last", 32'(last1), 32'd0);
        chk("midrst_word", word1, 32'd0);
        chk("midrst_idx", 32'(idx1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("after_rst_quiet", 32'(valid1), 32'd0);
        end
        run_req(32'h10, 3, 1'b0);

        // LATENCY=0 instance: top-of-range address wraps into mem[1020..1023]
        sel = 1'b1;
        run_req(32'hFFFFFFFC, 0, 1'b0);
        run_req(32'h8, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // hard time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_refill_rv32.md
# imem_refill_rv32

Line-refill responder for the RV32 instruction cache. It owns the backing instruction memory array, accepts one miss request at a time from the cache controller, waits a programmable access latency, then streams the addressed cache line back as a burst of 32-bit beats under valid/ready flow control. It sits between the I-cache miss path and the instruction store, and models the memory side that the cache stalls on.

## Interface
- MEMSIZE, 1024: backing store depth in 32-bit words; power of two.
- LINE_WORDS, 4: words per cache line and beats per burst; power of two, 2..16.
- LATENCY, 3: idle cycles between request acceptance and the first beat; 0..15.
- iCLK  in  1  clock; all state changes on posedge.
- iRST  in  1  reset; synchronous, active-high.
- iREQ  in  1  refill request strobe.
- iREQADDR  in  32  byte address of the missing instruction.
- oREADY  out  1  high when a request can be accepted (IDLE).
- oVALID  out  1  beat on oWORD/oWORDIDX is valid.
- oWORD  out  32  returned instruction word.
- oWORDIDX  out  log2(LINE_WORDS)  word offset of the beat within the line.
- oLAST  out  1  final beat of the burst.
- iRDY  in  1  cache accepts the current beat.
- iWE  in  1  memory load strobe (bootloader/testbench).
- iWADDR  in  32  byte address for load.
- iWDATA  in  32  load data.

## Operation
- Word index = iREQADDR[31:2] modulo MEMSIZE; line base = word index with the low log2(LINE_WORDS) bits cleared; byte bits [1:0] ignored.
- States: IDLE, WAIT, BURST.
- IDLE: oREADY=1. On iREQ, latch the line base and start offset, load the latency counter with LATENCY, go to WAIT (or directly to BURST if LATENCY=0).
- WAIT: counter decrements each cycle; at zero, present the first beat and go to BURST.
- BURST: beat held stable while iRDY=0. On oVALID&&iRDY, advance to the next offset; on the beat with oLAST=1 accepted, return to IDLE.
- Offset sequence wraps modulo LINE_WORDS; exactly LINE_WORDS beats per request.
- Requests while oREADY=0 are ignored, not queued.
- Memory read occurs when a beat is loaded, so data reflects all loads completed before that cycle.
- iWE writes mem[iWADDR[31:2] mod MEMSIZE] on any cycle in any state; a write in the same cycle a word is read returns the old value.
- Memory contents initialise to zero and are not cleared by iRST.

## Timing
- Reset values: oREADY=1, oVALID=0, oLAST=0, oWORD=0, oWORDIDX=0; state IDLE.
- Request accepted at posedge T (iREQ&&oREADY) -> oREADY=0 from T+1; first oVALID at T+1+LATENCY.
- With iRDY held high, beats on consecutive cycles; burst occupies LINE_WORDS cycles; oREADY=1 the cycle after the last beat is accepted.
- Minimum request-to-request spacing = LATENCY+LINE_WORDS+1 cycles.
- oVALID deasserts the cycle after the last beat is accepted; no bubble between beats when iRDY=1.
- All outputs registered; no combinational path from iREQ/iRDY to any output.
- iRST mid-WAIT or mid-BURST: next cycle all outputs at reset values, burst abandoned, no further beats.

## Configuration
- IMEM_CRITWORD_EN defined: critical-word-first; first beat is the requested word's offset, then wraps (e.g. offset 2 of 4: 2,3,0,1).
- Undefined: beats always start at offset 0 and run ascending (0,1,2,3) regardless of requested offset.

## Test plan
- Reset, load mem[0..3]=0x00000013,0x00100093,0x00200113,0x00300193; request addr 0x0, iRDY=1 -> oVALID at T+4, beats idx 0..3 with those words, oLAST on idx 3, oREADY high at T+8.
- Request addr 0x28 (word 10) with IMEM_CRITWORD_EN -> idx order 2,3,0,1 returning mem[10],mem[11],mem[8],mem[9]; without macro -> 0,1,2,3 returning mem[8..11].
- iRDY low for 3 cycles on beat 1 -> oWORD/oWORDIDX/oVALID stable for those cycles, burst resumes, still exactly 4 beats.
- Second iREQ during WAIT and during BURST -> ignored; only one burst produced; a fresh request after oREADY=1 is served normally.
- iRST asserted on beat 2 of a burst -> next cycle oVALID=0, oREADY=1, oLAST=0; new request to addr 0x10 returns mem[4..7] correctly.
- LATENCY=0 build, request addr 0xFFFFFFFC with MEMSIZE=1024 -> first beat at T+1, words taken from mem[1020..1023] (index wraps modulo MEMSIZE).
